// File: rtl/mtwo_acc.sv
`default_nettype none
// ============================================================================
//  Module   : mtwo_acc
//  Function : Multi-channel block accumulator. Sums LEN interleaved samples per
//             channel, then drains one signed sum per channel over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mtwo_acc #(
    parameter  int DATA_W = 16,
    parameter  int NCH    = 2,
    parameter  int LEN    = 4,
    localparam int ACC_W  = DATA_W + $clog2(LEN),
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              mtwo_acc_clk,
    input  logic              mtwo_acc_reset,
    input  logic              mtwo_acc_init,
    input  logic              mtwo_acc_in_disable,
    input  logic [DATA_W-1:0] mtwo_acc_in_data,
    input  logic              mtwo_acc_in_valid,
    output logic              mtwo_acc_in_ready,
    output logic [ACC_W-1:0]  mtwo_acc_out_data,
    output logic [CH_W-1:0]   mtwo_acc_out_chan,
    output logic              mtwo_acc_out_valid,
    input  logic              mtwo_acc_out_ready,
    output logic              mtwo_acc_busy
);

    localparam int                c_cntW    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [0:0]        c_accum   = 1'b0;
    localparam logic [0:0]        c_drain   = 1'b1;
    localparam logic [CH_W-1:0]   c_lastCh  = CH_W'(NCH - 1);
    localparam logic [c_cntW-1:0] c_lastCnt = c_cntW'(LEN - 1);

    logic [0:0]               r_state;
    logic [CH_W-1:0]          r_chPtr;
    logic [CH_W-1:0]          r_drainPtr;
    logic [c_cntW-1:0]        r_cnt;
    logic signed [ACC_W-1:0]  r_acc [NCH];

    logic                     w_resetInt;
    logic                     w_inFire;
    logic                     w_outFire;
    logic                     w_lastBeat;
    logic signed [ACC_W-1:0]  w_sample;

    assign w_resetInt = mtwo_acc_reset | mtwo_acc_init;
    assign w_sample   = ACC_W'($signed(mtwo_acc_in_data));
    assign w_lastBeat = (r_cnt == c_lastCnt) && (r_chPtr == c_lastCh);

    // Ready is derived from state and control only, never from in_valid.
    assign mtwo_acc_in_ready  = (r_state == c_accum) & ~mtwo_acc_in_disable & ~w_resetInt;
    assign w_inFire           = mtwo_acc_in_valid & mtwo_acc_in_ready;
    assign mtwo_acc_out_valid = (r_state == c_drain);
    assign w_outFire          = mtwo_acc_out_valid & mtwo_acc_out_ready;
    assign mtwo_acc_out_chan  = r_drainPtr;
    assign mtwo_acc_out_data  = mtwo_acc_out_valid ? r_acc[r_drainPtr] : '0;
    assign mtwo_acc_busy      = (r_state == c_drain) | (r_cnt != '0) | (r_chPtr != '0);

    always_ff @(posedge mtwo_acc_clk) begin
        if (w_resetInt) begin
            r_state    <= c_accum;
            r_chPtr    <= '0;
            r_cnt      <= '0;
            r_drainPtr <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                c_accum: begin
                    if (w_inFire) begin
                        // First beat of a block overwrites, so no clear pass is needed.
                        r_acc[r_chPtr] <= (r_cnt == '0) ? w_sample : r_acc[r_chPtr] + w_sample;
                        if (w_lastBeat) begin
                            r_state    <= c_drain;
                            r_chPtr    <= '0;
                            r_cnt      <= '0;
                            r_drainPtr <= '0;
                        end else if (r_chPtr == c_lastCh) begin
                            r_chPtr <= '0;
                            r_cnt   <= r_cnt + c_cntW'(1);
                        end else begin
                            r_chPtr <= r_chPtr + CH_W'(1);
                        end
                    end
                end
                c_drain: begin
                    if (w_outFire) begin
                        if (r_drainPtr == c_lastCh) begin
                            r_state    <= c_accum;
                            r_drainPtr <= '0;
                        end else begin
                            r_drainPtr <= r_drainPtr + CH_W'(1);
                        end
                    end
                end
                default: r_state <= c_accum;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mtwo_acc.md
# mtwo_acc

Parametrised multi-channel block accumulator in the mTWO family. Takes a channel-interleaved sample stream, sums LEN consecutive samples per channel for NCH channels, then drains one sum per channel over a valid/ready output. It inherits the family's clock, reset, init and in_disable control set, where init acts as a soft reset. It sits between a sample source and downstream per-channel processing.

## Interface
- DATA_W, 16, input sample width, signed two's complement
- NCH, 2, channel count, ≥1
- LEN, 4, samples per channel per block, ≥1
- ACC_W (derived, not overridable), DATA_W + $clog2(LEN), sum width; no overflow is possible
- CH_W (derived), max(1, $clog2(NCH))
- mtwo_acc_clk  in  1  clock, all logic on the rising edge
- mtwo_acc_reset  in  1  synchronous, active-high reset
- mtwo_acc_init  in  1  synchronous soft clear, identical effect to reset; reset_i = reset | init
- mtwo_acc_in_disable  in  1  freezes input acceptance; output side unaffected
- mtwo_acc_in_data  in  DATA_W  sample
- mtwo_acc_in_valid  in  1  sample present
- mtwo_acc_in_ready  out  1  sample accepted when valid & ready
- mtwo_acc_out_data  out  ACC_W  channel sum, signed
- mtwo_acc_out_chan  out  CH_W  channel index of out_data
- mtwo_acc_out_valid  out  1  sum present
- mtwo_acc_out_ready  in  1  sum consumed when valid & ready
- mtwo_acc_busy  out  1  block in progress (partial or draining)

## Operation
- States: ACCUM, DRAIN. Registers: ch_ptr (0..NCH-1), cnt (0..LEN-1), drain_ptr (0..NCH-1), acc[NCH] of ACC_W.
- in_ready = (state==ACCUM) & ~in_disable & ~reset_i. It never depends on in_valid.
- Accepted beat in ACCUM, with channel = ch_ptr:
  - if cnt==0: acc[ch] ← sext(in_data); otherwise acc[ch] ← acc[ch] + sext(in_data).
  - ch_ptr increments. When ch_ptr wraps from NCH-1 to 0, cnt increments.
  - Beat with cnt==LEN-1 and ch_ptr==NCH-1 is the last beat: state → DRAIN, ch_ptr and cnt → 0, drain_ptr → 0.
- DRAIN:
  - out_valid=1, out_chan=drain_ptr, out_data=acc[drain_ptr].
  - On each handshake, drain_ptr increments.
  - Handshake at drain_ptr==NCH-1 returns the state to ACCUM.
- Once raised, out_valid holds and out_data/out_chan stay stable until the handshake.
- in_disable:
  - In ACCUM: no beats accepted; counters and acc hold.
  - In DRAIN: no effect.
- busy = (state==DRAIN) | (cnt!=0) | (ch_ptr!=0).
- reset_i (any state, any cycle), next state:
  - state ACCUM; ch_ptr, cnt, drain_ptr and all acc = 0.
  - During the reset_i cycle itself, in_ready=0 and any in_valid beat is ignored.
- Reset values: in_ready 0 while reset_i is high, otherwise 1 in the first cycle after (unless disabled); out_valid 0; out_data 0; out_chan 0; busy 0.
- NCH=1: ch_ptr is constant 0. LEN=1: every beat completes its channel.

## Timing
- Input accepted at most one beat per cycle.
- Last beat accepted at edge t → out_valid=1 with acc[0] (including the last beat) from cycle t+1.
- With out_ready held high, DRAIN lasts exactly NCH cycles. in_ready returns high in the cycle after the final output handshake.
- Peak throughput: one block per NCH·LEN + NCH cycles.
- No combinational path from in_valid to in_ready. out_ready affects only the next-state logic.

## Test plan
- Basic block, defaults: drive stream 1,10,2,20,3,30,4,40 with out_ready=1 → outputs (chan 0, 10) then (chan 1, 100) on consecutive cycles; in_ready low for exactly 2 cycles; busy low afterwards.
- Signed extremes, defaults (ACC_W=18): ch0 receives -32768 ×4 and ch1 receives 32767 ×4 → sums -131072 and 131068, no wrap.
- Output backpressure: hold out_ready=0 for 5 cycles after DRAIN entry → out_valid stays 1, out_chan=0 and out_data=10 stable, in_ready=0; releasing out_ready gives the same sequence as the basic block.
- in_disable mid-block: after 3 accepted beats, assert in_disable for 4 cycles with in_valid=1 → in_ready=0 and no accumulation; resume → same sums as the basic block.
- init after 5 beats, then a fresh block of all-ones → sums (0,4),(1,4) with no residue; the same check with reset asserted during DRAIN → out_valid=0 on the next cycle and no further outputs.
- NCH=3, LEN=1, DATA_W=8, random in_valid gaps: stream 5,-6,7 → sums 5,-6,7 on chans 0,1,2; ACC_W=8.
